apb_xfer_ctrl: RTL and testbench

//  APB requester-side controller that sequences single read/write transfers onto a shared APB bus.

---
 rtl/apb_xfer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_apb_xfer_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: APB requester that turns one upstream request at a time
// into a SETUP/ACCESS transfer on a shared bus and returns one response beat.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_xfer_ctrl #(
  parameter int NSLV    = 2,
  parameter int SEL_LSB = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  output logic              resp_err,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [7:0]        paddr,
  output logic [7:0]        pwdata,
  input  logic [NSLV*8-1:0] prdata,
  input  logic [NSLV-1:0]   pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] OFF_MASK = 8'((1 << SEL_LSB) - 1);

  state_t            state_q, state_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [7:0]        paddr_q, paddr_d;
  logic [7:0]        pwdata_q, pwdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
`ifdef APB_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`endif

  logic [7:0]        idx_full;
  logic              dec_ok;
  logic [NSLV-1:0]   dec_onehot;
  logic              pready_sel;
  logic [7:0]        rdata_sel;

  // Slave index from the upper address bits; out-of-range indices are decode errors.
  assign idx_full = req_addr >> SEL_LSB;
  assign dec_ok   = (idx_full < 8'(NSLV));

  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_dec
      assign dec_onehot[gi] = (idx_full == 8'(gi));
    end
  endgenerate

  // Only the selected slave's ready matters; psel_q is one-hot or zero.
  assign pready_sel = |(pready & psel_q);

  // Read-data mux steered by the held slave select.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) rdata_sel = rdata_sel | prdata[8*i +: 8];
    end
  end

  assign req_ready  = (state_q == IDLE) && !preset;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Next-state and next-output computation; every output is loaded one edge ahead.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_ok) begin
            psel_d   = dec_onehot;
            pwrite_d = req_write;
            paddr_d  = req_addr & OFF_MASK;
            pwdata_d = req_wdata;
            state_d  = SETUP;
          end else begin
            // No bus activity: answer the bad address straight away.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = pwrite_q ? 8'h00 : rdata_sel;
          psel_d       = '0;
          penable_d    = 1'b0;
          state_d      = RESP;
`ifdef APB_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT)) begin
          // Slave never answered: release the bus and report an error.
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          psel_d       = '0;
          penable_d    = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer silently.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Directed bench for apb_xfer_ctrl with two behavioural APB slaves
// (programmable wait states, forced-ready override, 32-byte memories).
module tb_apb_xfer_ctrl;

  localparam int NSLV = 2;
  localparam int TMO  = 15;

  logic              pclk = 1'b0;
  logic              preset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [7:0]        req_addr;
  logic [7:0]        req_wdata;
  logic              resp_valid;
  logic [7:0]        resp_rdata;
  logic              resp_err;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [7:0]        pwdata;
  logic [NSLV*8-1:0] prdata;
  logic [NSLV-1:0]   pready;

  always #5 pclk = ~pclk;

  apb_xfer_ctrl #(.NSLV(NSLV), .SEL_LSB(5), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // ---------------- slave models ----------------
  logic [7:0] mem [NSLV][32];
  int         wait_cfg [NSLV];
  int         acc_cnt [NSLV];
  logic [NSLV-1:0] force_rdy;

  always_comb begin
    pready = '0;
    prdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      pready[i] = (psel[i] && penable && (acc_cnt[i] >= wait_cfg[i])) || force_rdy[i];
      prdata[8*i +: 8] = mem[i][paddr[4:0]];
    end
  end

  always @(posedge pclk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (psel[i] && penable && !pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      else acc_cnt[i] <= 0;
      if (psel[i] && penable && pready[i] && pwrite) mem[i][paddr[4:0]] <= pwdata;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int resp_cnt = 0;
  int bad_onehot = 0;
  int acc_at[$];

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready) acc_at.push_back(cyc);
    if ($countones(psel) > 1 || (penable && psel == '0)) bad_onehot <= bad_onehot + 1;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // One request; returns response fields, ACCESS cycle count, edges from accept to response.
  task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic e, output int acc,
                          output int lat, output logic [NSLV-1:0] sel_seen);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick;
    req_valid = 1'b0;
    lat = 0; acc = 0; sel_seen = '0;
    while (!resp_valid && lat < 300) begin
      sel_seen = sel_seen | psel;
      if (penable) acc++;
      tick;
      lat++;
    end
    if (!resp_valid) chk("resp_bound", 32'd0, 32'd1);
    rd = resp_rdata; e = resp_err;
    $display("xfer w=%0d addr=%02h wdata=%02h -> rdata=%02h err=%0d access=%0d lat=%0d",
             w, a, d, rd, e, acc, lat);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]      rd;
    logic            e;
    int              acc, lat, n0, a0, r0, k, guard;
    logic [NSLV-1:0] ss;

    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; force_rdy = '0;
    for (int i = 0; i < NSLV; i++) wait_cfg[i] = 0;
    tick; tick;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_req_ready_held", 32'(req_ready), 32'd0);
    preset = 1'b0;
    #1;
    chk("rst_req_ready_rel", 32'(req_ready), 32'd1);

    // Write 0xA5 to slave0 offset 3, zero wait states, phase by phase.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h03; req_wdata = 8'hA5;
    tick;
    req_valid = 1'b0;
    chk("wr_setup_psel", 32'(psel), 32'd1);
    chk("wr_setup_penable", 32'(penable), 32'd0);
    chk("wr_setup_paddr", 32'(paddr), 32'h03);
    chk("wr_setup_pwdata", 32'(pwdata), 32'hA5);
    chk("wr_setup_pwrite", 32'(pwrite), 32'd1);
    chk("wr_setup_ready", 32'(req_ready), 32'd0);
    tick;
    chk("wr_access_penable", 32'(penable), 32'd1);
    chk("wr_access_psel", 32'(psel), 32'd1);
    tick;
    chk("wr_resp_valid", 32'(resp_valid), 32'd1);
    chk("wr_resp_err", 32'(resp_err), 32'd0);
    chk("wr_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("wr_resp_psel", 32'(psel), 32'd0);
    chk("wr_resp_penable", 32'(penable), 32'd0);
    tick;
    chk("wr_resp_drop", 32'(resp_valid), 32'd0);
    chk("wr_ready_again", 32'(req_ready), 32'd1);
    chk("wr_mem", 32'(mem[0][3]), 32'hA5);
    $display("xfer w=1 addr=03 wdata=a5 phase-checked");

    // Preload slave1 offset 3 through the bus.
    run_xfer(1'b1, 8'h23, 8'hA5, rd, e, acc, lat, ss);
    chk("pre_err", 32'(e), 32'd0);
    chk("pre_lat", 32'(lat), 32'd2);

    // Read slave1 with two wait states; slave0 ready forced high must be ignored.
    wait_cfg[1] = 2; force_rdy[0] = 1'b1;
    run_xfer(1'b0, 8'h23, 8'h00, rd, e, acc, lat, ss);
    force_rdy[0] = 1'b0; wait_cfg[1] = 0;
    chk("rd_rdata", 32'(rd), 32'hA5);
    chk("rd_err", 32'(e), 32'd0);
    chk("rd_access_cycles", 32'(acc), 32'd3);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_psel", 32'(ss), 32'd2);

    // Decode error: index 2 with two slaves.
    run_xfer(1'b0, 8'h45, 8'h00, rd, e, acc, lat, ss);
    chk("dec_err", 32'(e), 32'd1);
    chk("dec_rdata", 32'(rd), 32'd0);
    chk("dec_lat", 32'(lat), 32'd0);
    chk("dec_no_psel", 32'(ss), 32'd0);

    // Reset asserted for two cycles in the middle of ACCESS.
    wait_cfg[1] = 1000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h21;
    tick;
    req_valid = 1'b0;
    tick;
    chk("rm_in_access", 32'(penable), 32'd1);
    n0 = resp_cnt;
    preset = 1'b1;
    tick; tick;
    chk("rm_psel", 32'(psel), 32'd0);
    chk("rm_penable", 32'(penable), 32'd0);
    preset = 1'b0;
    #1;
    chk("rm_ready", 32'(req_ready), 32'd1);
    tick; tick; tick;
    chk("rm_no_resp", 32'(resp_cnt - n0), 32'd0);
    wait_cfg[1] = 0;
    $display("xfer reset-abort read addr=21");

    // Four back-to-back writes with req_valid held.
    a0 = acc_at.size(); r0 = resp_cnt; k = 0; guard = 0;
    req_write = 1'b1; req_addr = 8'h08; req_wdata = 8'h10; req_valid = 1'b1;
    while (k < 4 && guard < 60) begin
      tick;
      guard++;
      if (acc_at.size() - a0 > k) begin
        $display("xfer w=1 addr=%02h wdata=%02h accepted at cycle %0d", req_addr, req_wdata, acc_at[a0 + k]);
        k++;
        if (k < 4) begin
          req_addr = 8'h08 + 8'(k); req_wdata = 8'h10 + 8'(k);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    tick; tick; tick; tick;
    chk("b2b_accepts", 32'(acc_at.size() - a0), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (a0 + i < acc_at.size()) chk("b2b_gap", 32'(acc_at[a0 + i] - acc_at[a0 + i - 1]), 32'd4);
    end
    chk("b2b_resps", 32'(resp_cnt - r0), 32'd4);
    for (int i = 0; i < 4; i++) chk("b2b_mem", 32'(mem[0][8 + i]), 32'(8'h10 + 8'(i)));
    chk("onehot", 32'(bad_onehot), 32'd0);

`ifdef APB_TIMEOUT_EN
    // Stuck slave: counter reaches TIMEOUT on the 16th ACCESS cycle.
    wait_cfg[1] = 1000;
    run_xfer(1'b0, 8'h21, 8'h00, rd, e, acc, lat, ss);
    chk("to_err", 32'(e), 32'd1);
    chk("to_rdata", 32'(rd), 32'd0);
    chk("to_access_cycles", 32'(acc), 32'(TMO + 1));
    wait_cfg[1] = 0;
    run_xfer(1'b1, 8'h22, 8'h5A, rd, e, acc, lat, ss);
    chk("to_next_err", 32'(e), 32'd0);
    chk("to_next_lat", 32'(lat), 32'd2);
    chk("to_next_mem", 32'(mem[1][2]), 32'h5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
